// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory arbiter.
package mem_arb_pkg;

  // Wait counter width: covers LATENCY-1 for LATENCY up to 15.
  localparam int unsigned MEM_ARB_LAT_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } arb_state_e;

  typedef enum logic {
    OwnIc,
    OwnDc
  } arb_owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between I-cache and D-cache requests.
// With MEM_ARB_STARVE_GUARD_EN defined, a saturating streak counter of contested
// D-cache wins forces the I-cache through once it reaches MAX_DC_STREAK.
module mem_arb_pick
  import mem_arb_pkg::*;
`ifdef MEM_ARB_STARVE_GUARD_EN
#(
  parameter int unsigned MAX_DC_STREAK = 3
)
`endif
(
`ifdef MEM_ARB_STARVE_GUARD_EN
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_arb,
`endif
  input  logic       i_ic_req,
  input  logic       i_dc_req,
  output arb_owner_e o_owner
);

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned STREAK_W = $clog2(MAX_DC_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DC_STREAK);

  logic [STREAK_W-1:0] r_streak;
  logic                w_force_ic;

  assign w_force_ic = i_ic_req && (r_streak == STREAK_MAX);

  // D-cache wins unless only I-cache asks or the I-cache has been starved long enough.
  always_comb begin
    o_owner = (i_dc_req && !w_force_ic) ? OwnDc : OwnIc;
  end

  // Count D wins taken while the I-cache was waiting; any I win or idle I-cache clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak <= '0;
    end else if (i_arb) begin
      if (o_owner == OwnIc || !i_ic_req) begin
        r_streak <= '0;
      end else if (r_streak != STREAK_MAX) begin
        r_streak <= r_streak + 1'b1;
      end
    end
  end
`else
  // Strict D-cache priority.
  always_comb begin
    o_owner = i_dc_req ? OwnDc : OwnIc;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter between I-cache and D-cache traffic for the banked
// main memory. Sequences issue/stall/latency and returns data to the winner.
// Optional I-cache starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned LATENCY       = 4,
  parameter int unsigned MAX_DC_STREAK = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_grant,
  output logic              ic_done,
  output logic [DATA_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic              dc_wr,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_grant,
  output logic              dc_done,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_stall,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [MEM_ARB_LAT_W-1:0] LAT_LOAD = MEM_ARB_LAT_W'(LATENCY - 1);

  arb_state_e               r_state;
  arb_owner_e               r_owner;
  logic [MEM_ARB_LAT_W-1:0] r_cnt;
  logic                     r_ic_grant, r_dc_grant, r_ic_done, r_dc_done;
  logic                     r_mem_en, r_mem_wr;
  logic [ADDR_W-1:0]        r_mem_addr;
  logic [DATA_W-1:0]        r_mem_wdata, r_ic_rdata, r_dc_rdata;

  arb_owner_e               w_owner;
  logic                     w_arb;
  logic                     w_pick_dc;

  assign w_arb     = (r_state == StIdle) && (ic_req || dc_req);
  assign w_pick_dc = (w_owner == OwnDc);

`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_pick #(
    .MAX_DC_STREAK(MAX_DC_STREAK)
  ) u_pick (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_arb    (w_arb),
    .i_ic_req (ic_req),
    .i_dc_req (dc_req),
    .o_owner  (w_owner)
  );
`else
  mem_arb_pick u_pick (
    .i_ic_req (ic_req),
    .i_dc_req (dc_req),
    .o_owner  (w_owner)
  );
`endif

  // Transaction FSM; every output is a register so nothing combinational reaches the ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_owner     <= OwnIc;
      r_cnt       <= '0;
      r_ic_grant  <= 1'b0;
      r_dc_grant  <= 1'b0;
      r_ic_done   <= 1'b0;
      r_dc_done   <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_ic_rdata  <= '0;
      r_dc_rdata  <= '0;
    end else begin
      // Grant and done are single-cycle pulses.
      r_ic_grant <= 1'b0;
      r_dc_grant <= 1'b0;
      r_ic_done  <= 1'b0;
      r_dc_done  <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_arb) begin
            r_state     <= StIssue;
            r_owner     <= w_owner;
            r_mem_en    <= 1'b1;
            r_mem_wr    <= w_pick_dc & dc_wr;
            r_mem_addr  <= w_pick_dc ? dc_addr : ic_addr;
            r_mem_wdata <= w_pick_dc ? dc_wdata : '0;
            r_ic_grant  <= !w_pick_dc;
            r_dc_grant  <= w_pick_dc;
          end
        end
        StIssue: begin
          // Command stays on the bus unchanged while the bank is busy.
          if (!mem_stall) begin
            r_state  <= StWait;
            r_cnt    <= LAT_LOAD;
            r_mem_en <= 1'b0;
            r_mem_wr <= 1'b0;
          end
        end
        StWait: begin
          if (r_cnt == '0) begin
            r_state <= StDone;
            if (r_owner == OwnDc) begin
              r_dc_rdata <= mem_rdata;
              r_dc_done  <= 1'b1;
            end else begin
              r_ic_rdata <= mem_rdata;
              r_ic_done  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign ic_grant  = r_ic_grant;
  assign dc_grant  = r_dc_grant;
  assign ic_done   = r_ic_done;
  assign dc_done   = r_dc_done;
  assign ic_rdata  = r_ic_rdata;
  assign dc_rdata  = r_dc_rdata;
  assign mem_en    = r_mem_en;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus randomized traffic,
// with a transaction-level reference model checked by an independent monitor.
module tb_mem_arbiter;

  localparam int LAT  = 4;
  localparam int MAXS = 3;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ic_req, dc_req, dc_wr, mem_stall;
  logic [15:0] ic_addr, dc_addr, dc_wdata, mem_rdata;
  logic        ic_grant, ic_done, dc_grant, dc_done, mem_en, mem_wr;
  logic [15:0] ic_rdata, dc_rdata, mem_addr, mem_wdata;

  // Second instance with LATENCY=1, driven only by its directed test.
  logic        l1_ic_req, l1_dc_req, l1_dc_wr, l1_mem_stall;
  logic [15:0] l1_ic_addr, l1_dc_addr, l1_dc_wdata, l1_mem_rdata;
  logic        l1_ic_grant, l1_ic_done, l1_dc_grant, l1_dc_done, l1_mem_en, l1_mem_wr;
  logic [15:0] l1_ic_rdata, l1_dc_rdata, l1_mem_addr, l1_mem_wdata;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(LAT), .MAX_DC_STREAK(MAXS)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_grant(ic_grant), .ic_done(ic_done),
    .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_wr(dc_wr), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_grant(dc_grant), .dc_done(dc_done), .dc_rdata(dc_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_stall(mem_stall), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(1), .MAX_DC_STREAK(MAXS)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .ic_req(l1_ic_req), .ic_addr(l1_ic_addr), .ic_grant(l1_ic_grant), .ic_done(l1_ic_done),
    .ic_rdata(l1_ic_rdata),
    .dc_req(l1_dc_req), .dc_wr(l1_dc_wr), .dc_addr(l1_dc_addr), .dc_wdata(l1_dc_wdata),
    .dc_grant(l1_dc_grant), .dc_done(l1_dc_done), .dc_rdata(l1_dc_rdata),
    .mem_en(l1_mem_en), .mem_wr(l1_mem_wr), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_stall(l1_mem_stall), .mem_rdata(l1_mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Unwritten memory words read back as a fixed function of their address.
  function automatic logic [15:0] init_val(logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  // Environment memory (what the memory model holds) and reference-model memory.
  logic [15:0] rsp_mem [logic [15:0]];
  logic [15:0] mdl_mem [logic [15:0]];

  typedef struct {
    bit          dc;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } txn_t;

  txn_t exp_q[$];
  int   exp_done_cyc = -1;
  int   streak = 0;
  int   men_cnt = 0;
  int   done_cnt = 0;
  int   grant_cnt = 0;
  bit   prev_ic, prev_dc, prev_dc_wr;
  logic [15:0] prev_ic_addr, prev_dc_addr, prev_dc_wdata;

  bit rand_on = 1'b0;
  bit stall_on = 1'b0;
  int force_stall = 0;

  // Memory model: random stalls, LATENCY-cycle read return, garbage on other cycles.
  int          rsp_cnt = 0;
  logic [15:0] rsp_data = '0;
  initial begin
    mem_stall = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_rdata = 16'($urandom);
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) mem_rdata = rsp_data;
      end
      mem_stall = 1'b0;
      if (mem_en) begin
        if (force_stall > 0) begin
          mem_stall = 1'b1;
          force_stall--;
        end else begin
          mem_stall = stall_on && ($urandom_range(0, 2) == 0);
        end
        if (!mem_stall) begin
          rsp_cnt = LAT;
          if (mem_wr) begin
            rsp_mem[mem_addr] = mem_wdata;
            rsp_data = 16'($urandom);
          end else begin
            rsp_data = rsp_mem.exists(mem_addr) ? rsp_mem[mem_addr] : init_val(mem_addr);
          end
        end
      end
    end
  end

  // Random requesters: hold request and command until granted, then pick anew.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_on) begin
        if (!ic_req || ic_grant) begin
          ic_req  = ($urandom_range(0, 99) < 45);
          ic_addr = 16'($urandom_range(0, 31));
        end
        if (!dc_req || dc_grant) begin
          dc_req   = ($urandom_range(0, 99) < 55);
          dc_wr    = ($urandom_range(0, 1) == 1);
          dc_addr  = 16'($urandom_range(0, 31));
          dc_wdata = 16'($urandom);
        end
      end
    end
  end

  // Monitor: predicts the winner from the request rules, pushes the expected
  // transaction on grant and checks bus command, completion time and data.
  always @(negedge clk) begin
    txn_t t;
    bit   want_dc;
    if (!rst_n) begin
      exp_q.delete();
      exp_done_cyc = -1;
      streak = 0;
    end else begin
      if (ic_grant || dc_grant) begin
        grant_cnt++;
        want_dc = prev_dc && !(GUARD && prev_ic && streak == MAXS);
        chk("grant_has_request", 32'(prev_ic | prev_dc), 32'd1);
        chk("grant_exclusive", 32'(ic_grant & dc_grant), 32'd0);
        chk("grant_winner", 32'(dc_grant), 32'(want_dc));
        chk("grant_while_busy", exp_q.size(), 0);
        if (!want_dc || !prev_ic) streak = 0;
        else if (streak < MAXS) streak++;
        t.dc    = dc_grant;
        t.wr    = dc_grant && prev_dc_wr;
        t.addr  = dc_grant ? prev_dc_addr : prev_ic_addr;
        t.wdata = dc_grant ? prev_dc_wdata : 16'h0000;
        t.rdata = mdl_mem.exists(t.addr) ? mdl_mem[t.addr] : init_val(t.addr);
        if (t.wr) mdl_mem[t.addr] = t.wdata;
        exp_q.push_back(t);
        exp_done_cyc = -1;
      end
      if (mem_en) begin
        men_cnt++;
        chk("mem_en_has_txn", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          chk("mem_addr", mem_addr, exp_q[0].addr);
          chk("mem_wr", 32'(mem_wr), 32'(exp_q[0].wr));
          if (exp_q[0].wr) chk("mem_wdata", mem_wdata, exp_q[0].wdata);
          if (!mem_stall) exp_done_cyc = cyc + LAT + 1;
        end
      end
      if (ic_done || dc_done) begin
        done_cnt++;
        chk("done_exclusive", 32'(ic_done & dc_done), 32'd0);
        chk("done_has_txn", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          t = exp_q.pop_front();
          chk("done_owner", 32'(dc_done), 32'(t.dc));
          chk("done_cycle", cyc, exp_done_cyc);
          if (!t.wr) chk("rdata", t.dc ? dc_rdata : ic_rdata, t.rdata);
        end
      end else if (exp_q.size() != 0 && exp_done_cyc >= 0 && cyc > exp_done_cyc) begin
        chk("done_late", cyc, exp_done_cyc);
        void'(exp_q.pop_front());
      end
    end
    prev_ic       = ic_req;
    prev_dc       = dc_req;
    prev_dc_wr    = dc_wr;
    prev_ic_addr  = ic_addr;
    prev_dc_addr  = dc_addr;
    prev_dc_wdata = dc_wdata;
  end

  // One directed request from T0; returns grant and done cycle offsets (-1 on timeout).
  task automatic do_req(input bit is_dc, input bit wr, input logic [15:0] addr,
                        input logic [15:0] wd, output int tg, output int td);
    int t0;
    @(posedge clk); #1;
    if (is_dc) begin
      dc_req = 1'b1; dc_wr = wr; dc_addr = addr; dc_wdata = wd;
    end else begin
      ic_req = 1'b1; ic_addr = addr;
    end
    t0 = cyc;
    tg = -1;
    td = -1;
    for (int i = 0; i < 40 && td < 0; i++) begin
      @(negedge clk);
      if (tg < 0 && (is_dc ? dc_grant : ic_grant)) tg = cyc - t0;
      if (is_dc ? dc_done : ic_done) td = cyc - t0;
      if (td < 0) begin
        @(posedge clk); #1;
        if (tg >= 0) begin
          if (is_dc) dc_req = 1'b0;
          else ic_req = 1'b0;
        end
      end
    end
    if (is_dc) dc_req = 1'b0;
    else ic_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tg, td, t0, tdone;
    bit got;
    logic [15:0] rd;
    bit order [8];
    int ng;

    rst_n = 1'b0;
    ic_req = 0; ic_addr = 0; dc_req = 0; dc_wr = 0; dc_addr = 0; dc_wdata = 0;
    l1_ic_req = 0; l1_ic_addr = 0; l1_dc_req = 0; l1_dc_wr = 0; l1_dc_addr = 0;
    l1_dc_wdata = 0; l1_mem_stall = 0; l1_mem_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_strobes", {26'd0, ic_grant, ic_done, dc_grant, dc_done, mem_en, mem_wr}, 32'd0);
    chk("reset_bus", {mem_addr, mem_wdata}, 32'd0);
    chk("reset_rdata", {ic_rdata, dc_rdata}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single I-cache read.
    rsp_mem[16'h0040] = 16'h1234;
    mdl_mem[16'h0040] = 16'h1234;
    do_req(1'b0, 1'b0, 16'h0040, 16'h0000, tg, td);
    chk("ic_read_grant_cycle", tg, 1);
    chk("ic_read_done_cycle", td, LAT + 2);
    chk("ic_read_data", ic_rdata, 16'h1234);

    // D-cache write with two stall cycles.
    force_stall = 2;
    men_cnt = 0;
    do_req(1'b1, 1'b1, 16'h0100, 16'hBEEF, tg, td);
    chk("dc_write_grant_cycle", tg, 1);
    chk("dc_write_done_cycle", td, LAT + 4);
    chk("dc_write_mem_en_cycles", men_cnt, 3);

    // Both requesters held continuously.
    @(posedge clk); #1;
    ic_req = 1'b1; ic_addr = 16'h0200;
    dc_req = 1'b1; dc_wr = 1'b0; dc_addr = 16'h0300;
    ng = 0;
    for (int i = 0; i < 8 * (LAT + 3) + 20 && ng < 8; i++) begin
      @(negedge clk);
      if (ic_grant || dc_grant) begin
        order[ng] = dc_grant;
        ng++;
      end
    end
    @(posedge clk); #1;
    ic_req = 1'b0;
    dc_req = 1'b0;
    chk("contention_grants", ng, 8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("contention_order_%0d", k), 32'(order[k]),
          32'(GUARD ? ((k % (MAXS + 1)) != MAXS) : 1'b1));
    end
    repeat (LAT + 4) @(posedge clk);

    // Reset while waiting on memory.
    @(posedge clk); #1;
    ic_req = 1'b1; ic_addr = 16'h0044;
    @(posedge clk); #1;
    ic_req = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_strobes", {26'd0, ic_grant, ic_done, dc_grant, dc_done, mem_en, mem_wr},
        32'd0);
    chk("async_reset_bus", {mem_addr, mem_wdata}, 32'd0);
    chk("async_reset_rdata", {ic_rdata, dc_rdata}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (LAT + 4) @(posedge clk);
    chk("abandoned_no_done", done_cnt, 0);
    do_req(1'b0, 1'b0, 16'h0048, 16'h0000, tg, td);
    chk("after_reset_grant_cycle", tg, 1);
    chk("after_reset_done_cycle", td, LAT + 2);

    // D-cache request raised again during the done cycle.
    do_req(1'b1, 1'b0, 16'h0060, 16'h0000, tg, td);
    chk("reassert_first_done", td, LAT + 2);
    tdone = cyc;
    dc_req = 1'b1; dc_wr = 1'b0; dc_addr = 16'h0062;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (dc_grant) begin
        got = 1'b1;
        chk("reassert_grant_spacing", cyc - tdone, 2);
      end
    end
    if (!got) chk("reassert_grant_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    dc_req = 1'b0;
    repeat (LAT + 4) @(posedge clk);

    // LATENCY=1 instance.
    @(posedge clk); #1;
    l1_ic_req = 1'b1; l1_ic_addr = 16'h0010;
    t0 = cyc;
    tg = -1; td = -1; rd = '0;
    for (int i = 0; i < 10 && td < 0; i++) begin
      @(negedge clk);
      if (tg < 0 && l1_ic_grant) tg = cyc - t0;
      if (l1_ic_done) begin
        td = cyc - t0;
        rd = l1_ic_rdata;
      end
      @(posedge clk); #1;
      if (tg >= 0) l1_ic_req = 1'b0;
      l1_mem_rdata = (cyc - t0 == 2) ? 16'hC0DE : (16'($urandom) | 16'h0001);
    end
    l1_ic_req = 1'b0;
    chk("lat1_grant_cycle", tg, 1);
    chk("lat1_done_cycle", td, 3);
    chk("lat1_rdata", rd, 16'hC0DE);

    // Randomized mixed traffic with random stalls.
    grant_cnt = 0;
    stall_on = 1'b1;
    rand_on = 1'b1;
    repeat (3000) @(posedge clk);
    #1;
    rand_on = 1'b0;
    @(posedge clk); #2;
    ic_req = 1'b0;
    dc_req = 1'b0;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (LAT + 4) @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
    chk("random_traffic_volume", 32'(grant_cnt > 100), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single four-bank main memory between I-cache and D-cache miss/writeback traffic in the pipelined processor. Sits between `icache`/`dcache` controllers and the memory model. Accepts one transaction at a time, sequences the memory's issue/stall/latency protocol and returns completion with read data to the winning requester. D-cache has priority; an optional guard bounds I-cache starvation.

## Interface
Parameters:
- `ADDR_W`, 16, address width (word address)
- `DATA_W`, 16, data width
- `LATENCY`, 4, memory cycles from accepted issue to valid `mem_rdata`; legal range 1..15
- `MAX_DC_STREAK`, 3, consecutive contested D-cache wins before I-cache is forced through (guard only)

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1 system clock
- `rst_n` in 1 asynchronous active-low reset
- `ic_req` in 1 I-cache read request, held until `ic_grant`
- `ic_addr` in ADDR_W I-cache read address
- `ic_grant` out 1 one-cycle pulse: I-cache request accepted
- `ic_done` out 1 one-cycle pulse: `ic_rdata` valid
- `ic_rdata` out DATA_W read data
- `dc_req` in 1 D-cache request, held until `dc_grant`
- `dc_wr` in 1 1 = write, 0 = read
- `dc_addr` in ADDR_W D-cache address
- `dc_wdata` in DATA_W write data
- `dc_grant` out 1 one-cycle pulse: D-cache request accepted
- `dc_done` out 1 one-cycle pulse: access complete, `dc_rdata` valid for reads
- `dc_rdata` out DATA_W read data
- `mem_en` out 1 memory issue strobe
- `mem_wr` out 1 memory write enable
- `mem_addr` out ADDR_W memory address
- `mem_wdata` out DATA_W memory write data
- `mem_stall` in 1 memory refuses issue this cycle (bank busy)
- `mem_rdata` in DATA_W memory read data

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any `*_req`, pick winner, latch owner/addr/wr/wdata, → ISSUE; else stay.
- Pick: `dc_req` only → D; `ic_req` only → I; both → D unless guard fires.
- ISSUE: `mem_en`=1 with latched command; `*_grant` of owner high on first ISSUE cycle only. `mem_stall`=1 → stay (command held stable); else load wait counter with LATENCY−1, → WAIT.
- WAIT: decrement counter; when counter = 0 capture `mem_rdata` into owner's rdata register, → DONE.
- DONE: owner's `*_done`=1 for one cycle, → IDLE.
- Writes follow the same path; `dc_rdata` is don't-care after a write, but still updated.
- `*_rdata` hold last captured value until the next capture for that requester.
- Requester may drop `req` after `grant`; a `req` still high in DONE is treated as a new request in IDLE.
- Counters sized `$clog2` of their range, no wrap: wait counter stops at 0; streak counter saturates at MAX_DC_STREAK.

## Timing
- Reset (async assert): state IDLE; all outputs 0 (`*_grant`, `*_done`, `mem_en`, `mem_wr`, `mem_addr`, `mem_wdata`, `*_rdata`); streak 0. An in-flight transaction is abandoned with no `done`.
- All outputs registered or decoded from state only; no combinational path from `*_req` or `mem_stall` to outputs.
- Request sampled in IDLE at cycle T0 → grant/`mem_en` in T1 → with no stall, WAIT T2..T(1+LATENCY) → done at T(2+LATENCY). LATENCY=4: done at T6, IDLE at T7.
- Each stall cycle in ISSUE adds one cycle; grant is not re-pulsed.
- Minimum spacing between grants: LATENCY+3 cycles.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined: streak counter increments on each D grant made while `ic_req`=1, and clears on an I grant or when `ic_req`=0 at arbitration. When both request and streak = MAX_DC_STREAK, I-cache wins.
- Undefined: strict D-cache priority; streak logic absent; `MAX_DC_STREAK` ignored.

## Structure
- `mem_arb_pkg`: state enum (IDLE/ISSUE/WAIT/DONE), owner enum (OWN_IC/OWN_DC), `MEM_ARB_LAT_W` constant.
- Sub-module `mem_arb_pick`: combinational winner selection plus the guarded streak counter; top-level holds the FSM, command latches, wait counter and rdata registers.

## Test plan
- Single I read, addr 0x0040, `mem_rdata`=0x1234 on last WAIT cycle, LATENCY=4, no stall → `ic_grant` T1, `ic_done` T6, `ic_rdata`=0x1234.
- D write addr 0x0100 data 0xBEEF with 2 stall cycles → `mem_en`/`mem_wr` held T1–T3 with stable addr/data, `dc_done` at T8.
- `ic_req` and `dc_req` both held continuously, guard on, MAX_DC_STREAK=3 → grant order D,D,D,I,D,D,D,I. Guard off → D only while `dc_req` is held.
- `rst_n` low during WAIT → all outputs 0 immediately; after release no `done`, IDLE accepts a new request.
- `dc_req` reasserted in the DONE cycle → next `dc_grant` exactly 2 cycles after `dc_done`.
- LATENCY=1 → done at T3.
